// File: rtl/grn_attractor_ctrl.sv
// Tortoise/hare attractor sequencer for a bank of GRN node cells; one result record per initial state.
// Optional step limit: define GRN_ATTRACTOR_TIMEOUT_EN to bound each run at MAX_STEPS.
module grn_attractor_ctrl #(
  parameter int N_NODES   = 16,
  parameter int CNT_W     = 32,
  parameter int MAX_STEPS = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] first_state,
  input  logic [N_NODES-1:0] last_state,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  input  logic [N_NODES-1:0] s0_in,
  input  logic [N_NODES-1:0] s1_in,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N_NODES-1:0] res_init,
  output logic [CNT_W-1:0]   res_meet,
  output logic [CNT_W-1:0]   res_period,
  output logic               res_timeout,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STEP, S_CHECK, S_PSTEP, S_PCHECK, S_EMIT
  } state_e;

  state_e             state_q, state_d;
  logic [N_NODES-1:0] cur_q, cur_d, last_q, last_d;
  logic [CNT_W-1:0]   k_q, k_d, per_q, per_d, meet_q, meet_d;
  logic               tmo_q, tmo_d;
  logic               k_lim, per_lim;

  logic               reset_nos_q, reset_nos_d;
  logic [N_NODES-1:0] init_state_q, init_state_d;
  logic               start_s0_q, start_s0_d;
  logic               start_s1_q, start_s1_d;
  logic               res_valid_q, res_valid_d;
  logic [N_NODES-1:0] res_init_q, res_init_d;
  logic [CNT_W-1:0]   res_meet_q, res_meet_d;
  logic [CNT_W-1:0]   res_period_q, res_period_d;
  logic               res_timeout_q, res_timeout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  if (N_NODES < 1 || CNT_W < 1 || MAX_STEPS < 1) begin : g_bad_params
    $error("grn_attractor_ctrl: N_NODES, CNT_W and MAX_STEPS must be positive");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

`ifdef GRN_ATTRACTOR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] STEP_LIMIT = CNT_W'(MAX_STEPS);
  assign k_lim   = (k_q == STEP_LIMIT);
  assign per_lim = (per_q == STEP_LIMIT);
`else
  assign k_lim   = 1'b0;
  assign per_lim = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cur_q         <= '0;
      last_q        <= '0;
      k_q           <= '0;
      per_q         <= '0;
      meet_q        <= '0;
      tmo_q         <= 1'b0;
      reset_nos_q   <= 1'b0;
      init_state_q  <= '0;
      start_s0_q    <= 1'b0;
      start_s1_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      res_init_q    <= '0;
      res_meet_q    <= '0;
      res_period_q  <= '0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      last_q        <= last_d;
      k_q           <= k_d;
      per_q         <= per_d;
      meet_q        <= meet_d;
      tmo_q         <= tmo_d;
      reset_nos_q   <= reset_nos_d;
      init_state_q  <= init_state_d;
      start_s0_q    <= start_s0_d;
      start_s1_q    <= start_s1_d;
      res_valid_q   <= res_valid_d;
      res_init_q    <= res_init_d;
      res_meet_q    <= res_meet_d;
      res_period_q  <= res_period_d;
      res_timeout_q <= res_timeout_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    k_d     = k_q;
    per_d   = per_q;
    meet_d  = meet_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d   = first_state;
          last_d  = last_state;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        k_d     = '0;
        per_d   = '0;
        meet_d  = '0;
        tmo_d   = 1'b0;
        state_d = S_STEP;
      end
      S_STEP: begin
        k_d     = sat_inc(k_q);
        state_d = S_CHECK;
      end
      // s0 == s1 trivially at k = 1, so only even step counts may declare a meet
      S_CHECK: begin
        if (!k_q[0] && (s0_in == s1_in)) begin
          meet_d  = k_q;
          state_d = S_PSTEP;
        end else if (k_lim) begin
          meet_d  = k_q;
          tmo_d   = 1'b1;
          state_d = S_EMIT;
        end else begin
          state_d = S_STEP;
        end
      end
      S_PSTEP: begin
        per_d   = sat_inc(per_q);
        state_d = S_PCHECK;
      end
      S_PCHECK: begin
        if (s1_in == s0_in) begin
          state_d = S_EMIT;
        end else if (per_lim) begin
          tmo_d   = 1'b1;
          state_d = S_EMIT;
        end else begin
          state_d = S_PSTEP;
        end
      end
      S_EMIT: begin
        if (res_ready) begin
          if (cur_q == last_q) begin
            state_d = S_IDLE;
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q
  always_comb begin
    reset_nos_d   = (state_d == S_LOAD);
    start_s0_d    = (state_d == S_STEP);
    start_s1_d    = (state_d == S_STEP) || (state_d == S_PSTEP);
    busy_d        = (state_d != S_IDLE);
    init_state_d  = (state_d != S_IDLE) ? cur_d : '0;
    res_valid_d   = (state_d == S_EMIT);
    res_init_d    = (state_d == S_EMIT) ? cur_d : '0;
    res_meet_d    = (state_d == S_EMIT) ? meet_d : '0;
    res_period_d  = (state_d == S_EMIT) ? per_d : '0;
    res_timeout_d = (state_d == S_EMIT) && tmo_d;
    done_d        = (state_q == S_EMIT) && res_ready && (cur_q == last_q);
  end

  assign reset_nos   = reset_nos_q;
  assign init_state  = init_state_q;
  assign start_s0    = start_s0_q;
  assign start_s1    = start_s1_q;
  assign res_valid   = res_valid_q;
  assign res_init    = res_init_q;
  assign res_meet    = res_meet_q;
  assign res_period  = res_period_q;
  assign res_timeout = res_timeout_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Bench for grn_attractor_ctrl: a 4-node cell bank model with selectable update rule,
// and a reference model computing meet/period/latency from iterated powers of f.
module tb_grn_attractor_ctrl;
  localparam int N    = 4;
  localparam int CW   = 16;
  localparam int MAXS = 6;
`ifdef GRN_ATTRACTOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  first_state, last_state;
  logic          reset_nos, start_s0, start_s1;
  logic [N-1:0]  init_state;
  logic [N-1:0]  s0_m, s1_m;
  logic          res_valid, res_ready, res_timeout, busy, done;
  logic [N-1:0]  res_init;
  logic [CW-1:0] res_meet, res_period;

  int            fsel;
  logic [N-1:0]  lut [16];
  logic          ph;
  int            n_chk = 0;
  int            n_err = 0;

  grn_attractor_ctrl #(.N_NODES(N), .CNT_W(CW), .MAX_STEPS(MAXS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .first_state(first_state), .last_state(last_state),
    .reset_nos(reset_nos), .init_state(init_state),
    .start_s0(start_s0), .start_s1(start_s1),
    .s0_in(s0_m), .s1_in(s1_m),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_init(res_init), .res_meet(res_meet), .res_period(res_period),
    .res_timeout(res_timeout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] f_step(input logic [N-1:0] s);
    case (fsel)
      0:       return s;
      1:       return '0;
      2:       return {s[N-2:0], s[N-1]};
      default: return lut[s];
    endcase
  endfunction

  function automatic logic [N-1:0] fpow(input logic [N-1:0] s, input int n);
    logic [N-1:0] x;
    x = s;
    for (int i = 0; i < n; i++) x = f_step(x);
    return x;
  endfunction

  // Node-cell bank: s0 advances on every other start_s0 pulse, s1 on every start_s1 pulse
  initial begin
    s0_m = '0;
    s1_m = '0;
    ph   = 1'b0;
  end
  always @(posedge clk) begin
    if (reset_nos) begin
      s0_m <= init_state;
      s1_m <= init_state;
      ph   <= 1'b0;
    end else begin
      if (start_s0) begin
        if (!ph) s0_m <= f_step(s0_m);
        ph <= ~ph;
      end
      if (start_s1) s1_m <= f_step(s1_m);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: first even k with f^(k/2)(x) == f^k(x), then steps of f until s1 returns to s0
  task automatic model_rec(input logic [N-1:0] init, output int meet, output int per,
                           output bit to);
    logic [N-1:0] a, b;
    meet = 0;
    per  = 0;
    to   = 1'b0;
    for (int k = 1; k <= 4096; k++) begin
      if ((k % 2 == 0) && (fpow(init, k / 2) == fpow(init, k))) begin
        meet = k;
        break;
      end
      if (TO_EN && k == MAXS) begin
        meet = k;
        to   = 1'b1;
        break;
      end
    end
    if (!to) begin
      a = fpow(init, meet / 2);
      b = fpow(init, meet);
      for (int p = 1; p <= 4096; p++) begin
        b = f_step(b);
        if (b == a) begin
          per = p;
          break;
        end
        if (TO_EN && p == MAXS) begin
          per = p;
          to  = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_reset_nos"}, reset_nos, 0);
    check_eq({tag, "_init_state"}, init_state, 0);
    check_eq({tag, "_start_s0"}, start_s0, 0);
    check_eq({tag, "_start_s1"}, start_s1, 0);
    check_eq({tag, "_res_valid"}, res_valid, 0);
    check_eq({tag, "_res_init"}, res_init, 0);
    check_eq({tag, "_res_meet"}, res_meet, 0);
    check_eq({tag, "_res_period"}, res_period, 0);
    check_eq({tag, "_res_timeout"}, res_timeout, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
  endtask

  task automatic run_sweep(input logic [N-1:0] first, input logic [N-1:0] last,
                           input int stall_idx, input bit poke);
    int           t, idx, em, ep;
    bit           eto;
    logic [N-1:0] cur;
    @(negedge clk);
    first_state = first;
    last_state  = last;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    first_state = ~first;
    last_state  = ~last;
    cur = first;
    idx = 0;
    forever begin
      model_rec(cur, em, ep, eto);
      check_eq("load_reset_nos", reset_nos, 1);
      check_eq("load_init_state", init_state, cur);
      check_eq("load_busy", busy, 1);
      t = 1;
      while (!res_valid && t < 3000) begin
        @(negedge clk);
        t++;
        if (poke && idx == 0 && t == 3) begin
          start       = 1'b1;
          first_state = 4'hA;
          last_state  = 4'hB;
        end else begin
          start = 1'b0;
        end
      end
      start = 1'b0;
      if (!res_valid) begin
        check_eq("record_wait_expired", 0, 1);
        return;
      end
      check_eq("latency", t, 2 + 2 * em + 2 * ep);
      check_eq("res_init", res_init, cur);
      check_eq("res_meet", res_meet, em);
      check_eq("res_period", res_period, ep);
      check_eq("res_timeout", res_timeout, eto);
      if (idx == stall_idx) begin
        res_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check_eq("stall_valid", res_valid, 1);
          check_eq("stall_init", res_init, cur);
          check_eq("stall_meet", res_meet, em);
          check_eq("stall_period", res_period, ep);
        end
        res_ready = 1'b1;
      end
      @(negedge clk);
      check_eq("valid_after_accept", res_valid, 0);
      if (cur == last) begin
        check_eq("done_pulse", done, 1);
        check_eq("busy_after_sweep", busy, 0);
        @(negedge clk);
        check_eq("done_single", done, 0);
        return;
      end
      check_eq("done_mid_sweep", done, 0);
      cur = cur + 1'b1;
      idx++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w;
    bit  found;
    logic [N-1:0] f0;
    rst         = 1'b1;
    start       = 1'b0;
    res_ready   = 1'b1;
    first_state = '0;
    last_state  = '0;
    fsel        = 0;
    for (int i = 0; i < 16; i++) lut[i] = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;

    fsel = 0; run_sweep(4'h3, 4'h3, -1, 1'b0);   // identity, single record
    fsel = 1; run_sweep(4'h5, 4'h5, -1, 1'b0);   // constant zero
    fsel = 2; run_sweep(4'h1, 4'h1, -1, 1'b1);   // rotate ring, start poked while busy
    fsel = 0; run_sweep(4'hE, 4'h1, 1, 1'b0);    // wrap sweep, stall on second record

    repeat (6) begin
      fsel = 3;
      for (int i = 0; i < 16; i++) lut[i] = 4'($urandom_range(0, 15));
      f0 = 4'($urandom);
      run_sweep(f0, f0 + 4'($urandom_range(0, 2)), $urandom_range(0, 2), 1'b0);
    end

    // Abort a run while it is stepping the hare alone
    fsel = 0;
    @(negedge clk);
    first_state = 4'h7;
    last_state  = 4'h7;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    w     = 0;
    while (!found && w < 50) begin
      if (start_s1 && !start_s0) found = 1'b1;
      else begin
        @(negedge clk);
        w++;
      end
    end
    check_eq("reached_pstep", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("midrun_reset");
    rst = 1'b0;
    fsel = 2; run_sweep(4'h9, 4'h9, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
